// File: rtl/biu_ctrl.sv
// Bus interface unit: runs one 16-bit memory transaction per request with an
// ack handshake and a timeout, returning read data on a registered bus.
module biu_ctrl #(
    parameter int unsigned    TIMEOUT  = 15,
    parameter logic [15:0]    ERR_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  sel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        bus_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [15:0] rdata_n;
    logic [15:0] mem_addr_n;
    logic [15:0] mem_wdata_n;
    logic        mem_rd_n;
    logic        mem_wr_n;
    logic [7:0]  count, count_n;
    logic [7:0]  count_inc;
    logic        err_flag, err_flag_n;
    logic        is_read, is_read_n;
    logic        accept;

    assign accept    = cs && (sel != 2'b00);
    assign count_inc = (count == 8'hFF) ? count : count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdata     <= 16'h0000;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            count     <= 8'h00;
            err_flag  <= 1'b0;
            is_read   <= 1'b0;
        end else begin
            state     <= state_n;
            rdata     <= rdata_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_rd    <= mem_rd_n;
            mem_wr    <= mem_wr_n;
            count     <= count_n;
            err_flag  <= err_flag_n;
            is_read   <= is_read_n;
        end
    end

    // DONE accepts a new request just like IDLE so fetch pairs run back-to-back.
    always_comb begin
        state_n     = state;
        rdata_n     = rdata;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_rd_n    = mem_rd;
        mem_wr_n    = mem_wr;
        count_n     = count;
        err_flag_n  = err_flag;
        is_read_n   = is_read;

        case (state)
            IDLE, DONE: begin
                err_flag_n = 1'b0;
                if (accept) begin
                    mem_addr_n = addr;
                    if (sel == 2'b10) begin
                        mem_wdata_n = wdata;
                    end
                    is_read_n = sel[0];
                    mem_rd_n  = sel[0];
                    mem_wr_n  = (sel == 2'b10);
                    count_n   = 8'h00;
                    state_n   = WAIT;
                end else begin
                    state_n = IDLE;
                end
            end

            // An ack on the last allowed edge still counts as a normal completion.
            WAIT: begin
                if (mem_ack) begin
                    if (is_read) begin
                        rdata_n = mem_rdata;
                    end
                    mem_rd_n = 1'b0;
                    mem_wr_n = 1'b0;
                    state_n  = DONE;
                end else if (count_inc >= TO_VAL) begin
                    if (is_read) begin
                        rdata_n = ERR_DATA;
                    end
                    mem_rd_n   = 1'b0;
                    mem_wr_n   = 1'b0;
                    err_flag_n = 1'b1;
                    count_n    = count_inc;
                    state_n    = DONE;
                end else begin
                    count_n = count_inc;
                end
            end

            default: begin
                mem_rd_n = 1'b0;
                mem_wr_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    assign ready   = (state != WAIT);
    assign bus_err = (state == DONE) && err_flag;

endmodule

// File: tb/tb_biu_ctrl.sv
// Self-checking bench for biu_ctrl: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_biu_ctrl;

    localparam int unsigned TO = 15;
    localparam logic [15:0] ERRD = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        bus_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_rdata;

    // ack_k: edge after the request edge on which ack is sampled; 0 = never
    typedef struct {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ack_k;
        logic [15:0] mdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_strobes;
    } txn_t;

    txn_t vec [8];

    biu_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sel       (sel),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .bus_err   (bus_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: result depends only on type, ack delay and data.
    function automatic txn_t modelTxn(input logic [1:0] s, input logic [15:0] a,
                                      input logic [15:0] w, input int k,
                                      input logic [15:0] d, input logic [15:0] prev);
        txn_t t;
        bit   timed_out;
        timed_out     = (k == 0) || (k > int'(TO));
        t.sel         = s;
        t.addr        = a;
        t.wdata       = w;
        t.ack_k       = k;
        t.mdata       = d;
        t.exp_err     = timed_out;
        t.exp_strobes = timed_out ? int'(TO) : k;
        if (s == 2'b10) t.exp_rdata = prev;
        else            t.exp_rdata = timed_out ? ERRD : d;
        return t;
    endfunction

    // Starts at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
    task automatic applyStimulus(input txn_t t);
        int  strobes = 0;
        int  c;
        bit  both = 0;
        bit  moved = 0;
        checkOutput("readyBeforeReq", 16'(ready), 16'd1);
        cs = 1'b1; sel = t.sel; addr = t.addr; wdata = t.wdata;
        @(posedge clk); @(negedge clk);
        cs = 1'($urandom); sel = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        checkOutput("readyLowInWait", 16'(ready), 16'd0);
        checkOutput("memRdAtStart", 16'(mem_rd), 16'(t.sel[0]));
        checkOutput("memWrAtStart", 16'(mem_wr), 16'(t.sel == 2'b10));
        checkOutput("memAddr", mem_addr, t.addr);
        if (t.sel == 2'b10) checkOutput("memWdata", mem_wdata, t.wdata);
        for (c = 1; c <= 400; c++) begin
            if (ready) break;
            if (mem_rd || mem_wr) strobes++;
            if (mem_rd && mem_wr) both = 1;
            if (mem_addr !== t.addr) moved = 1;
            mem_ack   = (c == t.ack_k);
            mem_rdata = (c == t.ack_k) ? t.mdata : 16'($urandom);
            @(posedge clk); @(negedge clk);
            mem_ack = 1'b0;
        end
        cs = 1'b0; sel = 2'b00;
        checkOutput("completionWithinBound", 16'(ready), 16'd1);
        checkOutput("strobeCycles", 16'(strobes), 16'(t.exp_strobes));
        checkOutput("strobesBothHigh", 16'(both), 16'd0);
        checkOutput("addrStable", 16'(moved), 16'd0);
        checkOutput("strobeDropped", 16'(mem_rd | mem_wr), 16'd0);
        checkOutput("rdataDone", rdata, t.exp_rdata);
        checkOutput("busErrDone", 16'(bus_err), 16'(t.exp_err));
    endtask

    task automatic idleStep();
        cs = 1'b0; sel = 2'b00;
        @(posedge clk); @(negedge clk);
        checkOutput("idleReady", 16'(ready), 16'd1);
        checkOutput("idleBusErr", 16'(bus_err), 16'd0);
        checkOutput("idleStrobes", 16'(mem_rd | mem_wr), 16'd0);
    endtask

    initial begin
        txn_t t;
        int   k;
        logic [1:0] s;

        vec[0] = '{2'b11, 16'h0010, 16'h0000, 3,  16'hABCD, 16'hABCD, 1'b0, 3};
        vec[1] = '{2'b10, 16'h00F0, 16'h00AA, 1,  16'h5555, 16'hABCD, 1'b0, 1};
        vec[2] = '{2'b01, 16'h0100, 16'h0000, 0,  16'h2222, 16'hFFFF, 1'b1, 15};
        vec[3] = '{2'b01, 16'h0200, 16'h0000, 2,  16'h1111, 16'h1111, 1'b0, 2};
        vec[4] = '{2'b01, 16'h0300, 16'h0000, 15, 16'h0F0F, 16'h0F0F, 1'b0, 15};
        vec[5] = '{2'b11, 16'hFFFF, 16'h0000, 16, 16'h3333, 16'hFFFF, 1'b1, 15};
        vec[6] = '{2'b10, 16'hFFFF, 16'h1234, 0,  16'h4444, 16'hFFFF, 1'b1, 15};
        vec[7] = '{2'b01, 16'h0000, 16'h0000, 1,  16'h0000, 16'h0000, 1'b0, 1};

        reset = 1'b1; cs = 1'b0; sel = 2'b00; addr = 16'h0; wdata = 16'h0;
        mem_rdata = 16'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstReady", 16'(ready), 16'd1);
        checkOutput("rstBusErr", 16'(bus_err), 16'd0);
        checkOutput("rstRdata", rdata, 16'h0000);
        checkOutput("rstStrobes", 16'({mem_rd, mem_wr}), 16'd0);
        checkOutput("rstMemAddr", mem_addr, 16'h0000);
        checkOutput("rstMemWdata", mem_wdata, 16'h0000);
        reset = 1'b0;
        model_rdata = 16'h0000;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vec[i]);
            model_rdata = vec[i].exp_rdata;
            idleStep();
        end

        // Back-to-back fetch pair issued from the DONE cycle.
        applyStimulus(modelTxn(2'b11, 16'h0020, 16'h0, 1, 16'h1234, model_rdata));
        checkOutput("pairFirst", rdata, 16'h1234);
        applyStimulus(modelTxn(2'b11, 16'h0021, 16'h0, 2, 16'h5678, 16'h1234));
        checkOutput("pairSecond", rdata, 16'h5678);
        model_rdata = 16'h5678;
        idleStep();

        // Reset in the middle of a read, then a no-op request.
        cs = 1'b1; sel = 2'b01; addr = 16'h0400;
        @(posedge clk); @(negedge clk);
        cs = 1'b0; sel = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("midReadStrobe", 16'(mem_rd), 16'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("midRstRd", 16'(mem_rd), 16'd0);
        checkOutput("midRstReady", 16'(ready), 16'd1);
        checkOutput("midRstRdata", rdata, 16'h0000);
        checkOutput("midRstBusErr", 16'(bus_err), 16'd0);
        reset = 1'b0;
        model_rdata = 16'h0000;
        cs = 1'b1; sel = 2'b00; addr = 16'h0500;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            checkOutput("noopReady", 16'(ready), 16'd1);
            checkOutput("noopStrobes", 16'(mem_rd | mem_wr), 16'd0);
        end
        cs = 1'b0;

        // Randomized transactions checked against the model.
        for (int i = 0; i < 40; i++) begin
            s = 2'($urandom_range(1, 3));
            k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
            t = modelTxn(s, 16'($urandom), 16'($urandom), k, 16'($urandom), model_rdata);
            applyStimulus(t);
            model_rdata = t.exp_rdata;
            if ($urandom_range(0, 1) == 1) idleStep();
        end
        idleStep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
